// File: rtl/button_bank.sv
// button_bank: N independent push-button channels. Each channel has a
// two-flop synchroniser, a counter debouncer, registered press/release
// pulses and a long-press / auto-repeat state machine.
module button_bank #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 20,
  parameter int REPEAT_CYCLES   = 5,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] debounced,
  output logic [N_CH-1:0] p_edge,
  output logic [N_CH-1:0] n_edge,
  output logic [N_CH-1:0] any_edge,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] repeat_pulse
);

  // Counter widths; the repeat counter keeps at least one bit even when
  // auto-repeat is disabled so the declaration stays legal.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 2);

  // Terminal counts: each counter fires on the cycle it would reach its period.
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic          pin;
    logic          s1_q, s2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise, fall;
    logic          pe_q, ne_q, ae_q;
    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          lp_q, lp_d;
    logic          rp_q, rp_d;

    // Normalise polarity so everything downstream sees 1 = pressed.
    assign pin = (ACTIVE_LOW != 0) ? ~noisy_in[g] : noisy_in[g];

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= pin;
        s2_q <= s1_q;
      end
    end

    // Debounce next state: accept s2 once it has differed for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the old level restarts the count.
    always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      rise  = 1'b0;
      fall  = 1'b0;
      if (s2_q == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_d = s2_q;
        cnt_d = '0;
        rise  = s2_q;
        fall  = ~s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // Debounced level and edge pulses; pulses register alongside the level
    // so they appear in the first cycle the new level is visible.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb_q <= 1'b0;
        cnt_q <= '0;
        pe_q  <= 1'b0;
        ne_q  <= 1'b0;
        ae_q  <= 1'b0;
      end else begin
        deb_q <= deb_d;
        cnt_q <= cnt_d;
        pe_q  <= rise;
        ne_q  <= fall;
        ae_q  <= rise | fall;
      end
    end

    // Long-press FSM registers, including the registered pulse outputs.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
        hold_q  <= '0;
        rep_q   <= '0;
        lp_q    <= 1'b0;
        rp_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
        lp_q    <= lp_d;
        rp_q    <= rp_d;
      end
    end

    // Long-press FSM next state. A release accepted in the same cycle as a
    // pending long-press or repeat takes priority and suppresses the pulse.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      lp_d    = 1'b0;
      rp_d    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          hold_d = '0;
          rep_d  = '0;
          if (rise) begin
            state_d = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (hold_q == HOLD_LAST) begin
            state_d = ST_HELD;
            lp_d    = 1'b1;
            hold_d  = '0;
            rep_d   = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_HELD: begin
          if (fall) begin
            state_d = ST_IDLE;
            rep_d   = '0;
          end else if (REPEAT_CYCLES > 0) begin
            if (rep_q == REP_LAST) begin
              rp_d  = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_q + RW'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end
      endcase
    end

    assign debounced[g]    = deb_q;
    assign p_edge[g]       = pe_q;
    assign n_edge[g]       = ne_q;
    assign any_edge[g]     = ae_q;
    assign long_press[g]   = lp_q;
    assign repeat_pulse[g] = rp_q;
  end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: expected pulse events are queued with the
// edge they must appear on and checked cycle by cycle against the outputs.
module tb_button_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] noisy_in;
  logic [3:0] debounced, p_edge, n_edge, any_edge, long_press, repeat_pulse;

  int edge_cnt   = 0;
  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int         cyc;
    logic [3:0] pe;
    logic [3:0] ne;
    logic [3:0] lp;
    logic [3:0] rp;
  } ev_t;

  ev_t sb[$];

  logic [0:5] press_pat;
  logic [0:5] release_pat;

  button_bank #(
    .N_CH(4), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .noisy_in(noisy_in),
    .debounced(debounced), .p_edge(p_edge), .n_edge(n_edge), .any_edge(any_edge),
    .long_press(long_press), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s edge=%0d got=%h exp=%h", tag, edge_cnt, got, exp);
    end
  endtask

  task automatic expect_ev(input int cyc, input logic [3:0] pe, input logic [3:0] ne,
                           input logic [3:0] lp, input logic [3:0] rp);
    ev_t e;
    e.cyc = cyc;
    e.pe  = pe;
    e.ne  = ne;
    e.lp  = lp;
    e.rp  = rp;
    sb.push_back(e);
  endtask

  // One clock: sample on the falling edge and match pulses against the queue.
  task automatic step();
    logic [19:0] got;
    logic [19:0] exp;
    ev_t         e;
    bit          have;
    @(posedge clk);
    @(negedge clk);
    got  = {p_edge, n_edge, any_edge, long_press, repeat_pulse};
    exp  = '0;
    have = 1'b0;
    e    = '{cyc: 0, pe: 4'h0, ne: 4'h0, lp: 4'h0, rp: 4'h0};
    if (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      e    = sb.pop_front();
      have = 1'b1;
      exp  = {e.pe, e.ne, e.pe | e.ne, e.lp, e.rp};
    end
    if (have || got != '0) begin
      check("pulses", 32'(got), 32'(exp));
      if (have) check("pulse_edge", 32'(edge_cnt), 32'(e.cyc));
    end
  endtask

  task automatic step_until(input int target);
    while (edge_cnt < target) step();
  endtask

  initial begin
    int e0;
    int t;
    int lst;
    press_pat   = 6'b101101;
    release_pat = 6'b010010;
    reset_n     = 1'b1;
    noisy_in    = 4'h0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("reset_outputs", 32'({debounced, p_edge, n_edge, any_edge, long_press, repeat_pulse}), 32'h0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    check("idle_debounced", 32'(debounced), 32'h0);

    // ch0 press, long press, repeats, release coinciding with a due repeat
    e0 = edge_cnt + 1;
    noisy_in = 4'b0001;
    t = e0 + 5;
    expect_ev(t,      4'b0001, 4'h0,    4'h0,    4'h0);
    expect_ev(t + 20, 4'h0,    4'h0,    4'b0001, 4'h0);
    expect_ev(t + 25, 4'h0,    4'h0,    4'h0,    4'b0001);
    expect_ev(t + 30, 4'h0,    4'h0,    4'h0,    4'b0001);
    expect_ev(t + 35, 4'h0,    4'h0,    4'h0,    4'b0001);
    expect_ev(t + 40, 4'h0,    4'b0001, 4'h0,    4'h0);
    step_until(t - 1);
    check("deb_before_latency", 32'(debounced), 32'h0);
    step();
    check("deb_after_latency", 32'(debounced), 32'b0001);
    step_until(t + 34);
    noisy_in = 4'h0;
    step_until(t + 50);
    check("deb_released", 32'(debounced), 32'h0);

    // ch1 short glitch: too short to be accepted
    noisy_in = 4'b0010;
    repeat (3) step();
    noisy_in = 4'h0;
    repeat (8) begin
      step();
      check("glitch_debounced", 32'(debounced), 32'h0);
    end

    // ch2 bouncing press then bouncing release
    lst = 0;
    for (int i = 0; i < 6; i++) begin
      noisy_in = {1'b0, press_pat[i], 2'b00};
      lst = edge_cnt + 1;
      if (i == 5) expect_ev(lst + 5, 4'b0100, 4'h0, 4'h0, 4'h0);
      step();
    end
    step_until(lst + 5);
    check("bounce_press_deb", 32'(debounced), 32'b0100);
    for (int i = 0; i < 6; i++) begin
      noisy_in = {1'b0, release_pat[i], 2'b00};
      lst = edge_cnt + 1;
      if (i == 5) expect_ev(lst + 5, 4'h0, 4'b0100, 4'h0, 4'h0);
      step();
    end
    step_until(lst + 10);
    check("bounce_release_deb", 32'(debounced), 32'h0);

    // ch0 and ch3 together; release just after long press
    e0 = edge_cnt + 1;
    noisy_in = 4'b1001;
    t = e0 + 5;
    expect_ev(t,      4'b1001, 4'h0,    4'h0,    4'h0);
    expect_ev(t + 20, 4'h0,    4'h0,    4'b1001, 4'h0);
    expect_ev(t + 21, 4'h0,    4'b1001, 4'h0,    4'h0);
    step_until(t);
    check("dual_any_edge", 32'(any_edge), 32'b1001);
    step_until(t + 15);
    noisy_in = 4'h0;
    step_until(t + 30);

    // Reset in the middle of a press with the pin still held
    e0 = edge_cnt + 1;
    noisy_in = 4'b0001;
    t = e0 + 5;
    expect_ev(t, 4'b0001, 4'h0, 4'h0, 4'h0);
    step_until(t + 10);
    check("held_before_reset", 32'(debounced), 32'b0001);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({debounced, p_edge, n_edge, any_edge, long_press, repeat_pulse}), 32'h0);
    repeat (2) step();
    reset_n = 1'b1;
    e0 = edge_cnt + 1;
    t = e0 + 5;
    expect_ev(t,      4'b0001, 4'h0,    4'h0,    4'h0);
    expect_ev(t + 20, 4'h0,    4'h0,    4'b0001, 4'h0);
    expect_ev(t + 24, 4'h0,    4'b0001, 4'h0,    4'h0);
    step_until(t + 18);
    noisy_in = 4'h0;
    step_until(t + 35);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
